// File: rtl/add_acc_stream.sv
// add_acc_stream: streaming add/sub/accumulate unit with an in-order result FIFO.
// Ports: clk, rst (sync, active-high);
//   in_valid/in_ready + in_a, in_b, in_mode (00 add, 01 sub, 10 acc, 11 clear);
//   out_valid/out_ready + out_y (WIDTH+1 bits), out_ovf.
module add_acc_stream #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_y,
  output logic             out_ovf
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH:0]  r_y [DEPTH];
  logic            r_ovf [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic [WIDTH:0]  r_acc;

  logic            w_push;
  logic            w_pop;
  logic [PW-1:0]   w_head_nxt;
  logic [PW-1:0]   w_tail_nxt;
  logic [WIDTH+1:0] w_acc_sum;
  logic [WIDTH:0]  w_y;
  logic            w_ovf;
  logic [WIDTH:0]  w_acc_nxt;
  logic            w_acc_we;

  // Handshake flags depend only on registered count, so in_ready
  // never has a combinational path from out_ready.
  assign in_ready  = (r_count != FULL);
  assign out_valid = (r_count != '0);
  assign out_y     = r_y[r_head];
  assign out_ovf   = r_ovf[r_head];

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;

  assign w_head_nxt = (r_head == LAST) ? '0 : r_head + 1'b1;
  assign w_tail_nxt = (r_tail == LAST) ? '0 : r_tail + 1'b1;

  // One extra bit so the wrap of the accumulator is visible.
  assign w_acc_sum = {1'b0, r_acc} + {2'b00, in_a};

  always_comb begin
    w_y       = '0;
    w_ovf     = 1'b0;
    w_acc_nxt = r_acc;
    w_acc_we  = 1'b0;
    case (in_mode)
      2'b00: begin
        w_y = {1'b0, in_a} + {1'b0, in_b};
      end
      2'b01: begin
        w_y   = {1'b0, in_a} - {1'b0, in_b};
        w_ovf = (in_a < in_b);
      end
      2'b10: begin
        w_y       = w_acc_sum[WIDTH:0];
        w_ovf     = w_acc_sum[WIDTH+1];
        w_acc_nxt = w_acc_sum[WIDTH:0];
        w_acc_we  = 1'b1;
      end
      default: begin
        w_acc_nxt = '0;
        w_acc_we  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_acc   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_y[i]   <= '0;
        r_ovf[i] <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_y[r_tail]   <= w_y;
        r_ovf[r_tail] <= w_ovf;
        r_tail        <= w_tail_nxt;
        if (w_acc_we)
          r_acc <= w_acc_nxt;
      end
      if (w_pop)
        r_head <= w_head_nxt;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_add_acc_stream.sv
// Directed bench for add_acc_stream (WIDTH=4, DEPTH=2).
// Vector table for single transactions, hand sequences for flow control.
module tb_add_acc_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic [1:0] in_mode;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_y;
  logic       out_ovf;

  always #5 clk = ~clk;

  add_acc_stream #(.WIDTH(4), .DEPTH(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_y    (out_y),
    .out_ovf  (out_ovf)
  );

  typedef struct {
    logic [1:0] mode;
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] y;
    logic       ovf;
  } vec_t;

  vec_t tbl [11];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    rst = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [3:0] a,
                       input logic [3:0] b, input logic [1:0] m);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_mode  = m;
  endtask

  initial begin
    tbl[0]  = '{2'b00, 4'd1,  4'd3,  5'd4,  1'b0};
    tbl[1]  = '{2'b00, 4'd5,  4'd6,  5'd11, 1'b0};
    tbl[2]  = '{2'b00, 4'd7,  4'd8,  5'd15, 1'b0};
    tbl[3]  = '{2'b00, 4'd15, 4'd15, 5'd30, 1'b0};
    tbl[4]  = '{2'b01, 4'd3,  4'd5,  5'd30, 1'b1};
    tbl[5]  = '{2'b01, 4'd9,  4'd2,  5'd7,  1'b0};
    tbl[6]  = '{2'b10, 4'd15, 4'd7,  5'd15, 1'b0};
    tbl[7]  = '{2'b10, 4'd15, 4'd0,  5'd30, 1'b0};
    tbl[8]  = '{2'b10, 4'd15, 4'd9,  5'd13, 1'b1};
    tbl[9]  = '{2'b11, 4'd6,  4'd6,  5'd0,  1'b0};
    tbl[10] = '{2'b10, 4'd2,  4'd1,  5'd2,  1'b0};

    rst       = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 4'd0, 4'd0, 2'b00);
    tick;
    tick;
    rst = 1'b0;

    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_out_ovf", out_ovf, 0);

    // Table: one accept per cycle, result checked one cycle later.
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, tbl[i].a, tbl[i].b, tbl[i].mode);
      chk($sformatf("v%0d_in_ready", i), in_ready, 1);
      tick;
      in_valid = 1'b0;
      chk($sformatf("v%0d_valid", i), out_valid, 1);
      chk($sformatf("v%0d_y", i), out_y, tbl[i].y);
      chk($sformatf("v%0d_ovf", i), out_ovf, tbl[i].ovf);
    end
    tick;
    chk("tbl_drained", out_valid, 0);

    // Back-pressure with a full FIFO and a held third transaction.
    do_reset;
    out_ready = 1'b0;
    drive(1'b1, 4'd1, 4'd1, 2'b00);
    tick;
    drive(1'b1, 4'd2, 4'd2, 2'b00);
    chk("bp_in_ready1", in_ready, 1);
    chk("bp_head1", out_y, 2);
    tick;
    drive(1'b1, 4'd3, 4'd3, 2'b00);
    chk("bp_full_ready", in_ready, 0);
    tick;
    chk("bp_held_ready", in_ready, 0);
    chk("bp_stable_y", out_y, 2);
    out_ready = 1'b1;
    tick;
    chk("bp_ready_back", in_ready, 1);
    chk("bp_pop2", out_y, 4);
    tick;
    in_valid = 1'b0;
    chk("bp_pop3_valid", out_valid, 1);
    chk("bp_pop3", out_y, 6);
    tick;
    chk("bp_empty", out_valid, 0);

    // Simultaneous push/pop at count 1.
    out_ready = 1'b0;
    drive(1'b1, 4'd1, 4'd0, 2'b00);
    tick;
    chk("pp_first", out_y, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'(i + 2), 4'd1, 2'b00);
      tick;
      chk($sformatf("pp%0d_valid", i), out_valid, 1);
      chk($sformatf("pp%0d_ready", i), in_ready, 1);
      chk($sformatf("pp%0d_y", i), out_y, i + 3);
    end
    in_valid = 1'b0;
    tick;
    chk("pp_drained", out_valid, 0);

    // Reset with a busy FIFO and an accumulator of 10.
    do_reset;
    out_ready = 1'b0;
    drive(1'b1, 4'd10, 4'd0, 2'b10);
    tick;
    drive(1'b1, 4'd3, 4'd4, 2'b00);
    tick;
    chk("mr_full", in_ready, 0);
    drive(1'b1, 4'd5, 4'd0, 2'b10);
    out_ready = 1'b1;
    rst       = 1'b1;
    tick;
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("mr_out_valid", out_valid, 0);
    chk("mr_in_ready", in_ready, 1);
    chk("mr_out_y", out_y, 0);
    chk("mr_out_ovf", out_ovf, 0);
    drive(1'b1, 4'd1, 4'd0, 2'b10);
    tick;
    in_valid = 1'b0;
    chk("mr_acc_valid", out_valid, 1);
    chk("mr_acc_y", out_y, 1);
    chk("mr_acc_ovf", out_ovf, 0);
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
